sync_fifo_prog: RTL and testbench

//  Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count,

---
 rtl/sync_fifo_prog_pkg.sv | 28 ++
 rtl/sync_fifo_prog_if.sv | 38 +++
 rtl/sync_fifo_prog_ram.sv | 36 +++
 rtl/sync_fifo_prog.sv | 114 +++++++++++
 tb/tb_sync_fifo_prog.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_prog_pkg.sv
// Shared FIFO definitions: occupancy-width helper and the status flag bundle.
// async_fifo reuses this package as well.
package fifo_pkg;

    // The count must hold 0..depth inclusive, so it needs one bit more than an address.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    localparam fifo_status_t FIFO_STATUS_RESET = '{
        full:         1'b0,
        almost_full:  1'b0,
        empty:        1'b1,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Bundle of the FIFO write port, read port, flush and status outputs.
//
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0 at that edge;
// a read is taken when rd_en=1 and empty=0, and its word appears on rd_data with
// rd_valid=1 for exactly the following cycle. flush=1 overrides both requests.
interface sync_fifo_prog_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    import fifo_pkg::*;

    logic                         flush;
    logic                         wr_en;
    logic [WIDTH-1:0]             wr_data;
    logic                         full;
    logic                         almost_full;
    logic                         rd_en;
    logic [WIDTH-1:0]             rd_data;
    logic                         rd_valid;
    logic                         empty;
    logic                         almost_empty;
    logic [fifo_cnt_w(DEPTH)-1:0] count;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output full, almost_full, rd_data, rd_valid, empty, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/sync_fifo_prog_ram.sv
// Simple dual-port storage: synchronous write, registered read on read enable.
// The array itself is not reset so it maps onto block or distributed RAM.
module fifo_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: loads only on an accepted read, otherwise holds the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_prog #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input logic             clk,
    input logic             async_rst,
    sync_fifo_prog_if.slave bus
);
    import fifo_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = fifo_cnt_w(DEPTH);

    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_prog: DEPTH must be a power of two and at least 4");
        end
        if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
            $error("sync_fifo_prog: AE_THRESH must be below AF_THRESH");
        end
    endgenerate

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    fifo_status_t      status_q;
    fifo_status_t      status_next;
    logic              rd_valid_q;
    logic              wr_acc;
    logic              rd_acc;
    logic [WIDTH-1:0]  rd_data;

    // Accept decisions, next occupancy and next flag values (flags track the new count).
    always_comb begin
        wr_acc      = bus.wr_en & ~status_q.full & ~bus.flush;
        rd_acc      = bus.rd_en & ~status_q.empty & ~bus.flush;
        count_next  = count_q;
        status_next = status_q;
        if (bus.flush) begin
            count_next  = '0;
            status_next = FIFO_STATUS_RESET;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_next = count_q + CNT_W'(1);
                2'b01:   count_next = count_q - CNT_W'(1);
                default: count_next = count_q;
            endcase
            status_next.full         = (count_next == CNT_W'(DEPTH));
            status_next.almost_full  = (count_next >= CNT_W'(AF_THRESH));
            status_next.empty        = (count_next == '0);
            status_next.almost_empty = (count_next <= CNT_W'(AE_THRESH));
            status_next.overflow     = status_q.overflow  | (bus.wr_en & status_q.full);
            status_next.underflow    = status_q.underflow | (bus.rd_en & status_q.empty);
        end
    end

    // Pointer, occupancy, flag and read-valid registers.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            status_q   <= FIFO_STATUS_RESET;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_next;
            status_q   <= status_next;
            rd_valid_q <= rd_acc;
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end
        end
    end

    // A read and write never hit the same slot on one edge: reads need a non-empty
    // FIFO and writes need a non-full one, so no bypass path is required.
    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (async_rst),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign bus.rd_data      = rd_data;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count_q;
    assign bus.full         = status_q.full;
    assign bus.almost_full  = status_q.almost_full;
    assign bus.empty        = status_q.empty;
    assign bus.almost_empty = status_q.almost_empty;
    assign bus.overflow     = status_q.overflow;
    assign bus.underflow    = status_q.underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: directed scenarios plus a random phase, all checked
// against a queue-based model of the FIFO rules.
module tb_sync_fifo_prog;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic clk = 1'b0;
    logic async_rst;

    sync_fifo_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_prog #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .bus       (bus)
    );

    // Clock: posedges at 5, 15, 25 ...; inputs change on negedges.
    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
    logic             exp_ovf;
    logic             exp_udf;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = exp_q.size();
        check({tag, ":count"},        32'(bus.count), 32'(n));
        check({tag, ":full"},         32'(bus.full), 32'(n == DEPTH));
        check({tag, ":almost_full"},  32'(bus.almost_full), 32'(n >= AF));
        check({tag, ":empty"},        32'(bus.empty), 32'(n == 0));
        check({tag, ":almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE));
        check({tag, ":overflow"},     32'(bus.overflow), 32'(exp_ovf));
        check({tag, ":underflow"},    32'(bus.underflow), 32'(exp_udf));
        check({tag, ":rd_valid"},     32'(bus.rd_valid), 32'(exp_valid));
        check({tag, ":rd_data"},      bus.rd_data, exp_data);
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    // One clock: drive requests, predict the result of the edge, check after it.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r,
                         input logic f, input string tag);
        int n;
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        bus.flush   = f;
        n = exp_q.size();
        if (f) begin
            exp_q.delete();
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_udf   = 1'b0;
        end else begin
            exp_valid = r && (n > 0);
            if (w && n == DEPTH) exp_ovf = 1'b1;
            if (r && n == 0)     exp_udf = 1'b1;
            if (exp_valid)       exp_data = exp_q.pop_front();
            if (w && n < DEPTH)  exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_state(tag);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, '0, 1'b0, 1'b0, tag);
    endtask

    // Asynchronous reset pulse placed between clock edges, checked before any edge.
    task automatic pulse_reset(input string tag);
        #2;
        async_rst = 1'b1;
        #1;
        model_reset();
        check_state(tag);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.flush = 1'b0;
        #1;
        async_rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        async_rst   = 1'b1;
        model_reset();
        @(negedge clk);
        check_state("reset");
        async_rst = 1'b0;
        @(negedge clk);

        // 1: single word round trip
        cycle(1'b1, 32'hA5, 1'b0, 1'b0, "t1_wr");
        cycle(1'b0, '0, 1'b1, 1'b0, "t1_rd");
        check("t1_data", bus.rd_data, 32'hA5);
        idle("t1_idle");

        // 2: fill past full, drain past empty
        for (int i = 0; i <= DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0, "t2_fill");
        for (int i = 0; i <= DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0, "t2_drain");
        idle("t2_idle");

        // 3: full with continuous write+read
        cycle(1'b0, '0, 1'b0, 1'b1, "t3_flush");
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, "t3_fill");
        for (int i = 0; i < 20; i++)    cycle(1'b1, $urandom, 1'b1, 1'b0, "t3_both");
        while (exp_q.size() > 0)        cycle(1'b0, '0, 1'b1, 1'b0, "t3_drain");

        // 4: half full with continuous write+read, pointers wrap
        cycle(1'b0, '0, 1'b0, 1'b1, "t4_flush");
        for (int i = 0; i < 8; i++)  cycle(1'b1, $urandom, 1'b0, 1'b0, "t4_fill");
        for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b1, 1'b0, "t4_both");
        check("t4_count", 32'(bus.count), 32'd8);
        while (exp_q.size() > 0)     cycle(1'b0, '0, 1'b1, 1'b0, "t4_drain");

        // 5: flush beats a write, clears overflow
        for (int i = 0; i <= DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, "t5_fill");
        for (int i = 0; i < 6; i++)      cycle(1'b0, '0, 1'b1, 1'b0, "t5_rd");
        check("t5_pre_count", 32'(bus.count), 32'd10);
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b1, "t5_flush");
        check("t5_post_count", 32'(bus.count), 32'd0);
        idle("t5_idle");

        // 6: reset in the middle of a write burst
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, "t6_burst");
        bus.wr_en   = 1'b1;
        bus.wr_data = 32'hDEAD_BEEF;
        pulse_reset("t6_reset");
        cycle(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, "t6_wr");
        cycle(1'b0, '0, 1'b1, 1'b0, "t6_rd");
        check("t6_data", bus.rd_data, 32'hCAFE_F00D);
        idle("t6_idle");

        // Random traffic with phases biased toward filling or draining
        for (int blk = 0; blk < 8; blk++) begin
            int wp;
            wp = (blk % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 50; i++) begin
                logic w;
                logic r;
                logic f;
                w = ($urandom_range(0, 99) < wp);
                r = ($urandom_range(0, 99) < (100 - wp));
                f = ($urandom_range(0, 59) == 0);
                cycle(w, $urandom, r, f, "rand");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
